// File: rtl/bemicro_cv_dmaster_st_pkg.sv
// bemicro_cv_dmaster_st_pkg: byte-stream marker constants and decoder/encoder FSM states.
package bemicro_cv_dmaster_st_pkg;
  localparam logic [7:0] SOP_M    = 8'h7A;
  localparam logic [7:0] EOP_M    = 8'h7B;
  localparam logic [7:0] CHAN_M   = 8'h7C;
  localparam logic [7:0] ESC_M    = 8'h7D;
  localparam logic [7:0] ESC_MASK = 8'h20;
  typedef enum logic [1:0] {ST_IDLE, ST_ESC, ST_CHAN, ST_CHAN_ESC} state_e;
  function automatic logic is_marker(input logic [7:0] b);
    return b inside {SOP_M, EOP_M, CHAN_M, ESC_M};
  endfunction
endpackage

// File: rtl/bemicro_cv_ddr3_control_dmaster_b2p.sv
// bemicro_cv_ddr3_control_dmaster_b2p: byte stream to packet stream decoder.
// Channel tracking is built only when B2P_CHANNEL_EN is defined; otherwise out_channel is 0.
module bemicro_cv_ddr3_control_dmaster_b2p
  import bemicro_cv_dmaster_st_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_startofpacket,
  output logic       out_endofpacket,
  output logic [7:0] out_channel
);
  state_e     st_q, st_d;
  logic       acc, as_idle, emit;
  logic [7:0] byte_d;
  logic       sop_q, sop_d, eop_q, eop_d;
  logic       ov_q, ov_d, osop_q, osop_d, oeop_q, oeop_d;
  logic [7:0] od_q, od_d;

  assign in_ready = !ov_q || out_ready;
  assign acc      = in_valid && in_ready;
  // A framing marker seen while waiting for a channel byte abandons the channel load.
  assign as_idle  = st_q == ST_IDLE || (st_q == ST_CHAN && in_data inside {SOP_M, EOP_M, CHAN_M});

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st_q <= ST_IDLE;
    else st_q <= st_d;

  always_comb
    st_d = !acc ? st_q :
           as_idle ? (in_data == CHAN_M ? ST_CHAN : in_data == ESC_M ? ST_ESC : ST_IDLE) :
           (st_q == ST_CHAN && in_data == ESC_M) ? ST_CHAN_ESC : ST_IDLE;

  always_comb begin
    emit   = acc && (st_q == ST_ESC || (as_idle && !is_marker(in_data)));
    byte_d = st_q == ST_ESC ? in_data ^ ESC_MASK : in_data;
  end

  always_comb begin
    sop_d  = emit ? 1'b0 : sop_q | (acc && as_idle && in_data == SOP_M);
    eop_d  = emit ? 1'b0 : eop_q | (acc && as_idle && in_data == EOP_M);
    ov_d   = emit || (ov_q && !out_ready);
    od_d   = emit ? byte_d : od_q;
    osop_d = emit ? sop_q : osop_q;
    oeop_d = emit ? eop_q : oeop_q;
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      sop_q  <= 1'b0;
      eop_q  <= 1'b0;
      ov_q   <= 1'b0;
      od_q   <= 8'h00;
      osop_q <= 1'b0;
      oeop_q <= 1'b0;
    end else begin
      sop_q  <= sop_d;
      eop_q  <= eop_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      osop_q <= osop_d;
      oeop_q <= oeop_d;
    end

  assign out_valid         = ov_q;
  assign out_data          = od_q;
  assign out_startofpacket = osop_q;
  assign out_endofpacket   = oeop_q;

`ifdef B2P_CHANNEL_EN
  logic [7:0] ch_q, ch_d, och_q, och_d;
  always_comb begin
    ch_d  = !acc ? ch_q :
            st_q == ST_CHAN_ESC ? in_data ^ ESC_MASK :
            (st_q == ST_CHAN && !is_marker(in_data)) ? in_data : ch_q;
    och_d = emit ? ch_q : och_q;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ch_q  <= 8'h00;
      och_q <= 8'h00;
    end else begin
      ch_q  <= ch_d;
      och_q <= och_d;
    end
  assign out_channel = och_q;
`else
  assign out_channel = 8'h00;
`endif
endmodule

// File: doc/bemicro_cv_ddr3_control_dmaster_b2p.md
BEMICRO_CV_DDR3_CONTROL_DMASTER_B2P -- requirements
Module: bemicro_cv_ddr3_control_dmaster_b2p

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset: clk input 1, reset_n input 1.
REQ-002 SHALL have in_ready output 1: byte-stream sink ready.
REQ-003 SHALL have in_valid input 1: byte-stream sink valid.
REQ-004 SHALL have in_data input 8: encoded byte.
REQ-005 SHALL have out_ready input 1: packet-stream source backpressure.
REQ-006 SHALL have out_valid output 1: decoded data byte valid.
REQ-007 SHALL have out_data output 8: decoded payload byte.
REQ-008 SHALL have out_startofpacket output 1: first byte of packet.
REQ-009 SHALL have out_endofpacket output 1: last byte of packet.
REQ-010 SHALL have out_channel output 8: current channel number.

Function
REQ-011 SHALL transfer an input byte when in_valid && in_ready, and an output beat when out_valid && out_ready.
REQ-012 SHALL drive in_ready = !out_valid || out_ready (combinational), for marker and data bytes alike.
REQ-013 SHALL decode markers: 0x7A = SOP, 0x7B = EOP, 0x7C = CHANNEL, 0x7D = ESCAPE; every other byte is data.
REQ-014 SHALL use FSM states IDLE, ESC, CHAN, CHAN_ESC; reset state IDLE.
REQ-015 SHALL, in IDLE: on 0x7A set sop_pend; on 0x7B set eop_pend; on 0x7C go CHAN; on 0x7D go ESC; on a data byte emit it.
REQ-016 SHALL, in ESC: emit (in_data XOR 0x20) as data regardless of value, then return to IDLE.
REQ-017 SHALL, in CHAN: on 0x7D go CHAN_ESC; on 0x7A/0x7B/0x7C abandon the channel and process the byte as in IDLE; on any other byte load channel = in_data and go IDLE.
REQ-018 SHALL, in CHAN_ESC: load channel = in_data XOR 0x20, then go IDLE.
REQ-019 SHALL register each emitted byte into the output register with out_startofpacket = sop_pend and out_endofpacket = eop_pend, then clear both pending flags; latency from accepted data byte to out_valid = 1 cycle.
REQ-020 SHALL hold out_data, SOP, EOP and out_channel stable while out_valid && !out_ready.
REQ-021 SHALL keep out_channel sticky until the next channel load, and SHALL sample it into the output register with each data byte.
REQ-022 SHALL apply both flags to the same next data byte when SOP and EOP markers both precede it (1-byte packet).
REQ-023 SHALL OR a repeated SOP or EOP marker into the already-pending flag, without error.
REQ-024 SHALL clear out_valid on an output handshake with no simultaneous new data byte; on a simultaneous handshake and new byte, SHALL load the new byte and keep out_valid high.

Reset
REQ-025 SHALL, while reset_n is low: out_valid=0, out_data=0x00, out_startofpacket=0, out_endofpacket=0, out_channel=0x00, sop_pend=0, eop_pend=0, FSM=IDLE.
REQ-026 SHALL, on reset mid-packet or mid-escape, discard the partial state; the first post-reset byte SHALL be decoded from IDLE.

Configuration
REQ-027 SHALL support macro B2P_CHANNEL_EN: when defined, channel behaviour is as in REQ-017/018/021.
REQ-028 SHALL, without B2P_CHANNEL_EN, still consume the CHAN/CHAN_ESC byte (FSM unchanged), discard its value, and tie out_channel to 0x00.

Structure
REQ-029 SHALL place marker constants (0x7A-0x7D), the escape mask 0x20, and the FSM state enum in shared package bemicro_cv_dmaster_st_pkg, reused by the packets-to-bytes encoder.
REQ-030 SHALL be a single module with no sub-modules; the output register is inline.

Verification
REQ-031 SHALL cover: stream 7A 7C 05 11 22 7B 33, out_ready=1 -> beats 11(SOP,ch5), 22(ch5), 33(EOP,ch5), 1 cycle latency each.
REQ-032 SHALL cover: 7D 5A 7D 5D -> data 7A then 7D, no SOP/EOP.
REQ-033 SHALL cover: 7A 7B 44 -> single beat 44 with SOP=1 and EOP=1.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with a beat held -> in_ready=0, output stable; out_ready rises -> transfer, then in_ready=1.
REQ-035 SHALL cover: 7C 7D 5C 66 -> channel 0x7C on beat 66; and 7C 7A 77 -> channel unchanged, 77 with SOP.
REQ-036 SHALL cover: reset_n asserted after 7D, then 7A 10 -> beat 10 with SOP, channel 0.
